riscv_trap_seq: RTL

Trap/return sequencer for the machine-mode CSR path. It sits directly upstream of the CSR register file and drives that file's write-enable, address and data inputs, and reads its `csr_dout`. On an ECALL, illegal instruction or MRET it stalls the pipeline. It then runs a fixed multi-cycle sequence: save `mepc`/`mcause`, fetch `mtvec` or `mepc`, and issue a one-cycle PC redirect to fetch.

---
 rtl/riscv_trap_seq.sv | 105 ++++++++++
 1 files changed

// File: rtl/riscv_trap_seq.sv
// Trap/return sequencer for the machine-mode CSR path.
// Saves mepc/mcause on a trap, fetches mtvec or mepc, then issues a one-cycle PC redirect.
module riscv_trap_seq #(
    parameter int                     WORD_LENGTH = 32,
    parameter logic [WORD_LENGTH-1:0] MEPC_ADDR   = 'h341,
    parameter logic [WORD_LENGTH-1:0] MCAUSE_ADDR = 'h342,
    parameter logic [WORD_LENGTH-1:0] MTVEC_ADDR  = 'h305
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   trap_req,
    input  logic [WORD_LENGTH-1:0] trap_cause,
    input  logic [WORD_LENGTH-1:0] trap_pc,
    input  logic                   mret_req,
    input  logic [WORD_LENGTH-1:0] csr_dout,
    output logic                   busy,
    output logic                   csr_write_en,
    output logic [WORD_LENGTH-1:0] csr_addr,
    output logic [WORD_LENGTH-1:0] csr_data,
    output logic                   redirect_valid,
    output logic [WORD_LENGTH-1:0] redirect_pc
);

    localparam logic [WORD_LENGTH-1:0] ALIGN_MASK = {{(WORD_LENGTH-2){1'b1}}, 2'b00};

    typedef enum logic [2:0] {
        IDLE,
        SAVE_EPC,
        SAVE_CAUSE,
        FETCH_VEC,
        LOAD_EPC,
        REDIRECT
    } state_t;

    state_t                 state, next_state;
    logic [WORD_LENGTH-1:0] pc_q, cause_q, tgt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pc_q    <= '0;
            cause_q <= '0;
            tgt_q   <= '0;
        end else begin
            state <= next_state;
            if (state == IDLE && trap_req) begin
                pc_q    <= trap_pc;
                cause_q <= trap_cause;
            end
            // mtvec mode bits are ignored: only direct mode is supported
            if (state == FETCH_VEC || state == LOAD_EPC) begin
                tgt_q <= csr_dout & ALIGN_MASK;
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (trap_req) begin
                    next_state = SAVE_EPC;
                end else if (mret_req) begin
                    next_state = LOAD_EPC;
                end
            end
            SAVE_EPC:   next_state = SAVE_CAUSE;
            SAVE_CAUSE: next_state = FETCH_VEC;
            FETCH_VEC:  next_state = REDIRECT;
            LOAD_EPC:   next_state = REDIRECT;
            REDIRECT:   next_state = IDLE;
            default:    next_state = IDLE;
        endcase
    end

    // Outputs depend only on the registered state and the latched registers
    always_comb begin
        busy           = (state != IDLE);
        csr_write_en   = 1'b0;
        csr_addr       = '0;
        csr_data       = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        case (state)
            SAVE_EPC: begin
                csr_write_en = 1'b1;
                csr_addr     = MEPC_ADDR;
                csr_data     = pc_q & ALIGN_MASK;
            end
            SAVE_CAUSE: begin
                csr_write_en = 1'b1;
                csr_addr     = MCAUSE_ADDR;
                csr_data     = cause_q;
            end
            FETCH_VEC: csr_addr = MTVEC_ADDR;
            LOAD_EPC:  csr_addr = MEPC_ADDR;
            REDIRECT: begin
                redirect_valid = 1'b1;
                redirect_pc    = tgt_q;
            end
            default: ;
        endcase
    end

endmodule
